// File: rtl/mul_pipeline.sv
// Five-stage pipelined multiplier with collapsing backpressure and per-stage RAW tags.
// Define MUL_HIGH_EN to add mul_op_i and the MULH/MULHSU/MULHU high-word variants.
module mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int ROB_IDX_WIDTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dec_valid_i,
    input  logic                      dec_is_mul_i,
    input  logic                      bubble_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  logic [ROB_IDX_WIDTH-1:0]  rob_idx_i,
`ifdef MUL_HIGH_EN
    input  logic [1:0]                mul_op_i,
`endif
    input  logic                      wb_ready_i,
    output logic                      ex1_valid_o,
    output logic                      ex2_valid_o,
    output logic                      ex3_valid_o,
    output logic                      ex4_valid_o,
    output logic                      ex5_valid_o,
    output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
    output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
    output logic                      wb_valid_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [ROB_IDX_WIDTH-1:0]  wb_rob_idx_o
);

`ifdef MUL_HIGH_EN
    localparam int PW = 2*DATA_WIDTH + 2;
`else
    localparam int PW = DATA_WIDTH;
`endif
    // Operand B is consumed CW bits per stage over EX2..EX4.
    localparam int CW = (PW + 2) / 3;

    typedef struct packed {
        logic                      v;
        logic [REGISTER_WIDTH-1:0] wr;
        logic [ROB_IDX_WIDTH-1:0]  rob;
`ifdef MUL_HIGH_EN
        logic [1:0]                op;
`endif
        logic [PW-1:0]             a;
        logic [PW-1:0]             b;
        logic [PW-1:0]             acc;
    } stage_t;

    stage_t                    st_q [1:4];
    stage_t                    st_d [1:4];
    stage_t                    entry;
    logic                      ex5_valid_q, ex5_valid_d;
    logic [REGISTER_WIDTH-1:0] ex5_wr_q, ex5_wr_d;
    logic [ROB_IDX_WIDTH-1:0]  ex5_rob_q, ex5_rob_d;
    logic [DATA_WIDTH-1:0]     ex5_data_q, ex5_data_d;
    logic [5:1]                hold;
    logic                      accept;

    // One shift-and-add step: acc += a * b[CW-1:0]; then a <<= CW, b >>= CW.
    function automatic stage_t step(input stage_t s);
        stage_t t;
        t     = s;
        t.acc = s.acc + s.a * PW'(s.b[CW-1:0]);
        t.a   = s.a << CW;
        t.b   = s.b >> CW;
        return t;
    endfunction

    always_comb begin
        hold[5] = ex5_valid_q & ~wb_ready_i;
        hold[4] = st_q[4].v & hold[5];
        hold[3] = st_q[3].v & hold[4];
        hold[2] = st_q[2].v & hold[3];
        hold[1] = st_q[1].v & hold[2];
        accept  = dec_valid_i & dec_is_mul_i & ~bubble_i & ~stall_i & ~flush_i & ~hold[1];
    end

    always_comb begin
        entry     = '0;
        entry.v   = 1'b1;
        entry.wr  = wr_reg_i;
        entry.rob = rob_idx_i;
`ifdef MUL_HIGH_EN
        entry.op  = mul_op_i;
        entry.a   = {{(PW-DATA_WIDTH){rs1_data_i[DATA_WIDTH-1] & (mul_op_i == 2'b01 || mul_op_i == 2'b10)}},
                     rs1_data_i};
        entry.b   = {{(PW-DATA_WIDTH){rs2_data_i[DATA_WIDTH-1] & (mul_op_i == 2'b01)}}, rs2_data_i};
`else
        entry.a   = rs1_data_i;
        entry.b   = rs2_data_i;
`endif
    end

    always_comb begin
        st_d[1] = st_q[1];
        if (!hold[1]) begin
            if (accept) st_d[1] = entry;
            else        st_d[1].v = 1'b0;
        end
        st_d[2] = hold[2] ? st_q[2] : step(st_q[1]);
        st_d[3] = hold[3] ? st_q[3] : step(st_q[2]);
        st_d[4] = hold[4] ? st_q[4] : step(st_q[3]);

        ex5_valid_d = ex5_valid_q;
        ex5_wr_d    = ex5_wr_q;
        ex5_rob_d   = ex5_rob_q;
        ex5_data_d  = ex5_data_q;
        if (!hold[5]) begin
            ex5_valid_d = st_q[4].v;
            ex5_wr_d    = st_q[4].wr;
            ex5_rob_d   = st_q[4].rob;
`ifdef MUL_HIGH_EN
            ex5_data_d  = (st_q[4].op == 2'b00) ? st_q[4].acc[DATA_WIDTH-1:0]
                                                : st_q[4].acc[2*DATA_WIDTH-1:DATA_WIDTH];
`else
            ex5_data_d  = st_q[4].acc[DATA_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q[1]     <= '0;
            st_q[2]     <= '0;
            st_q[3]     <= '0;
            st_q[4]     <= '0;
            ex5_valid_q <= 1'b0;
            ex5_wr_q    <= '0;
            ex5_rob_q   <= '0;
            ex5_data_q  <= '0;
        end else begin
            st_q[1]     <= st_d[1];
            st_q[2]     <= st_d[2];
            st_q[3]     <= st_d[3];
            st_q[4]     <= st_d[4];
            ex5_valid_q <= ex5_valid_d;
            ex5_wr_q    <= ex5_wr_d;
            ex5_rob_q   <= ex5_rob_d;
            ex5_data_q  <= ex5_data_d;
        end
    end

    assign ex1_valid_o  = st_q[1].v;
    assign ex2_valid_o  = st_q[2].v;
    assign ex3_valid_o  = st_q[3].v;
    assign ex4_valid_o  = st_q[4].v;
    assign ex5_valid_o  = ex5_valid_q;
    assign ex1_wr_reg_o = st_q[1].wr;
    assign ex2_wr_reg_o = st_q[2].wr;
    assign ex3_wr_reg_o = st_q[3].wr;
    assign ex4_wr_reg_o = st_q[4].wr;
    assign wb_valid_o   = ex5_valid_q;
    assign wb_data_o    = ex5_data_q;
    assign wb_wr_reg_o  = ex5_wr_q;
    assign wb_rob_idx_o = ex5_rob_q;

endmodule

// File: doc/mul_pipeline.md
Name: mul_pipeline

Overview:
- Five-stage pipelined multiplier (EX1..EX5), fed from decode in parallel with the ALU stage, alongside the hazard unit.
- Accepts one multiply per cycle from decode and retires results to writeback / ROB from EX5.
- Publishes per-stage valid and destination-register tags for RAW hazard detection; empty stages collapse so bubbles never block younger multiplies.

Parameters:
DATA_WIDTH, 32, operand/result width
REGISTER_WIDTH, 5, architectural register index width
ROB_IDX_WIDTH, 4, reorder-buffer tag width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode holds a valid instruction
dec_is_mul_i  in  1  decoded instruction is a multiply
bubble_i  in  1  hazard unit orders bubble into EX (no entry)
stall_i  in  1  hazard unit EX stall (no entry)
flush_i  in  1  branch/jump flush; kills the decode-stage candidate only
rs1_data_i  in  DATA_WIDTH  operand A
rs2_data_i  in  DATA_WIDTH  operand B
wr_reg_i  in  REGISTER_WIDTH  destination register
rob_idx_i  in  ROB_IDX_WIDTH  ROB tag
wb_ready_i  in  1  writeback arbiter grants EX5 this cycle
ex1_valid_o..ex5_valid_o  out  1 each  stage occupancy
ex1_wr_reg_o..ex4_wr_reg_o  out  REGISTER_WIDTH each  stage destination tags
wb_valid_o  out  1  equals ex5_valid_o
wb_data_o  out  DATA_WIDTH  EX5 result
wb_wr_reg_o  out  REGISTER_WIDTH  EX5 destination
wb_rob_idx_o  out  ROB_IDX_WIDTH  EX5 ROB tag

Behaviour:
- Reset: asynchronous, active-low. All valids 0; all tag, data and partial-product registers 0. Every output is 0 while rst_ni=0. Reset mid-operation discards all in-flight operations.
- Entry: accept = dec_valid_i & dec_is_mul_i & !bubble_i & !stall_i & !flush_i & !hold1. When accept=1, EX1 captures the operands, wr_reg_i and rob_idx_i, and ex1_valid goes to 1 next cycle.
- Hold chain (combinational, evaluated from EX5 backwards):
  - hold5 = ex5_valid & !wb_ready_i
  - holdk = exk_valid & hold(k+1), for k = 4..1
- Stage update:
  - A holding stage keeps its contents.
  - Otherwise stage k+1 loads stage k's contents, including its valid bit, so an empty stage k yields an invalid stage k+1.
  - EX1 loads the new entry when accept=1; otherwise it becomes invalid.
- Bubble collapse: when EX5 is blocked, younger ops advance into empty slots. hold1=1 only when all five stages are valid and wb_ready_i=0, which matches the hazard unit's stall_i.
- Retire: the op retires when ex5_valid & wb_ready_i. If stage 4 is valid in the same cycle, it moves into EX5 that cycle.
- Latency: an op accepted at edge N presents wb_valid_o=1 after edge N+5 when there is no backpressure. Throughput is 1 op/cycle.
- Arithmetic: wb_data_o = low DATA_WIDTH bits of rs1*rs2. This is sign-agnostic for the low word.
  - The multiply is split into partial products: EX1 registers operands, EX2-EX4 accumulate, EX5 holds the final result.
  - Partitioning is free, but the result must be bit-exact.
- Flush: flush_i only blocks entry that cycle. Ops already in EX1..EX5 are older than the branch and complete normally.
- Simultaneous events:
  - flush_i together with an otherwise-valid accept: no entry.
  - wb_ready_i rising while the pipe is full: the whole pipe advances and hold1=0, so a new entry is allowed in the same cycle.

Optional Feature:
- MUL_HIGH_EN defined: adds an input port mul_op_i (2 bits), captured at entry and carried down the pipe.
  - 00 MUL (low word)
  - 01 MULH (signed x signed, high word)
  - 10 MULHSU (signed x unsigned, high word)
  - 11 MULHU (unsigned x unsigned, high word)
  - Internal product width becomes 2*DATA_WIDTH+2 with sign extension.
- MUL_HIGH_EN undefined: no mul_op_i port; only the low-word result is produced.

Test Plan:
- Single op: rs1=7, rs2=6, wr_reg=3, wb_ready=1 at accept edge N -> wb_valid=1 after edge N+5, wb_data=42, wb_wr_reg=3; ex1..ex5_valid pulse one cycle each, in order.
- Back-to-back: 5 ops on consecutive cycles (0xFFFFFFFF*2, 3*5, 0x10000*0x10000, ...) -> results 0xFFFFFFFE, 15, 0 on consecutive cycles in issue order with correct rob_idx.
- Backpressure collapse: op A at N, idle at N+1, op B at N+2; hold wb_ready=0 from N+5 for 4 cycles -> B advances to EX4 behind A in EX5; on release A retires, then B the next cycle; no loss or duplication.
- Full-pipe stall: 5 ops in flight, wb_ready=0 -> all five valids=1; dec_valid & is_mul with stall_i=1 -> no entry; ops 6 and 7 enter only after wb_ready=1.
- Flush/bubble: flush_i=1 or bubble_i=1 with valid mul in decode -> ex1_valid stays 0; in-flight ops still retire with correct data.
- Reset mid-operation: rst_ni low with 3 ops in flight -> all valids 0 immediately (asynchronous); no wb_valid after release until a new op completes 5 cycles later.
